// File: rtl/edge_det_pkg.sv
// -----------------------------------------------------------------------------
// edge_det_pkg
// Shared definitions for the edge detector bank:
//   - edge_mode_e : per-channel detect mode encodings
//   - DB_CNT_W    : width of the per-channel debounce counter
//   - edge_match  : maps a mode and the rise/fall strobes to a pulse request
// -----------------------------------------------------------------------------
package edge_det_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  localparam int unsigned DB_CNT_W = 8;

  // Decide whether the current edge strobes match the configured mode.
  function automatic logic edge_match(input logic [1:0] mode,
                                      input logic       rise,
                                      input logic       fall);
    logic hit;
    case (mode)
      MODE_OFF:  hit = 1'b0;
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// -----------------------------------------------------------------------------
// edge_det_chan
// One channel of the edge detector bank: synchroniser, optional debounce
// filter, edge detection, pulse register, sticky flag and overflow flag.
//
// Optional feature: define EDGE_DET_DEBOUNCE_EN to insert a debounce filter
// between the synchroniser and the level output. Without it, DB_CYCLES has
// no effect and no counter exists.
//
// Parameters
//   SYNC_STAGES : synchroniser depth (>= 2)
//   DB_CYCLES   : debounce stability count (2..255)
// Ports
//   clk    in  : clock, rising edge
//   rst    in  : asynchronous active-high reset
//   sig    in  : asynchronous channel input
//   mode   in  : detect mode (see edge_det_pkg::edge_mode_e)
//   clr    in  : clears sticky and ovf
//   level  out : synchronised (and filtered) level
//   pulse  out : one-cycle registered pulse per matching edge
//   sticky out : latched event flag
//   ovf    out : event seen while sticky already set
// -----------------------------------------------------------------------------
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level,
  output logic       pulse,
  output logic       sticky,
  output logic       ovf
);

  // Elaboration-time parameter range checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("edge_det_chan: SYNC_STAGES must be at least 2");
  end
  if ((DB_CYCLES < 2) || (DB_CYCLES > 255)) begin : g_bad_db_cycles
    $error("edge_det_chan: DB_CYCLES must be in 2..255");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_out_s;
  logic                   level_s;
  logic                   level_dly_q;
  logic                   level_dly_d;
  logic                   rise_s;
  logic                   fall_s;
  logic                   pulse_q;
  logic                   pulse_d;
  logic                   sticky_q;
  logic                   sticky_d;
  logic                   ovf_q;
  logic                   ovf_d;

  // Synchroniser shift: stage 0 samples the raw input.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig};
  end

  // Synchroniser register chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out_s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DET_DEBOUNCE_EN
  localparam logic [DB_CNT_W-1:0] DB_LIMIT = DB_CNT_W'(DB_CYCLES);

  logic                level_q;
  logic                level_d;
  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;

  // Debounce: count consecutive cycles where the synchroniser disagrees
  // with the filtered level; toggle once the disagreement has lasted
  // DB_CYCLES edges. Any agreement restarts the count, rejecting glitches.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_out_s != level_q) begin
      if (cnt_q == (DB_LIMIT - {{(DB_CNT_W-1){1'b0}}, 1'b1})) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + {{(DB_CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_s = level_q;
`else
  // Without the filter the level is the last synchroniser stage itself.
  assign level_s = sync_out_s;
`endif

  // Edge detection, pulse request, sticky and overflow next state.
  // The detected event (pulse_d) sets sticky/ovf on the same edge that
  // registers the pulse, so the flags appear together with the pulse.
  always_comb begin
    level_dly_d = level_s;
    rise_s      = level_s & ~level_dly_q;
    fall_s      = ~level_s & level_dly_q;
    pulse_d     = edge_match(mode, rise_s, fall_s);

    // Set has priority over clear.
    if (pulse_d) begin
      sticky_d = 1'b1;
    end else if (clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end

    // Overflow: a new event while the previous one is still latched and
    // not being cleared on this edge.
    if (pulse_d && sticky_q && !clr) begin
      ovf_d = 1'b1;
    end else if (clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Edge history, pulse and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
      sticky_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
      sticky_q    <= sticky_d;
      ovf_q       <= ovf_d;
    end
  end

  assign level  = level_s;
  assign pulse  = pulse_q;
  assign sticky = sticky_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/edge_det_bank.sv
// -----------------------------------------------------------------------------
// edge_det_bank
// Bank of WIDTH independent edge detector channels with a shared interrupt.
//
// Optional feature: define EDGE_DET_DEBOUNCE_EN to add a per-channel debounce
// filter (DB_CYCLES stability count) ahead of edge detection.
//
// Parameters
//   WIDTH       : number of channels (1..32)
//   SYNC_STAGES : synchroniser depth per channel (>= 2)
//   DB_CYCLES   : debounce stability count (2..255), debounce builds only
// Ports
//   clk    in  : clock, rising edge
//   rst    in  : asynchronous active-high reset
//   sig    in  : [WIDTH]   asynchronous channel inputs
//   mode   in  : [2*WIDTH] per-channel mode at [2i+1:2i]
//   clr    in  : [WIDTH]   per-channel clear of sticky and ovf
//   irq_en in  : [WIDTH]   per-channel interrupt enable
//   level  out : [WIDTH]   synchronised (and filtered) levels
//   pulse  out : [WIDTH]   one-cycle edge pulses
//   sticky out : [WIDTH]   latched event flags
//   ovf    out : [WIDTH]   overflow flags
//   irq    out : OR of (sticky & irq_en); combinational from flops and irq_en
// -----------------------------------------------------------------------------
module edge_det_bank
  import edge_det_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sig,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  input  logic [WIDTH-1:0]   irq_en,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   pulse,
  output logic [WIDTH-1:0]   sticky,
  output logic [WIDTH-1:0]   ovf,
  output logic               irq
);

  // Elaboration-time parameter range check.
  if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
    $error("edge_det_bank: WIDTH must be in 1..32");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .sig    (sig[i]),
      .mode   (mode[2*i +: 2]),
      .clr    (clr[i]),
      .level  (level[i]),
      .pulse  (pulse[i]),
      .sticky (sticky[i]),
      .ovf    (ovf[i])
    );
  end

  // Interrupt is formed only from registered sticky flags and the enables,
  // so no combinational path exists from the channel inputs.
  always_comb begin
    irq = |(sticky & irq_en);
  end

endmodule

// File: tb/tb_edge_det_bank.sv
module tb_edge_det_bank;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DB = 4;
`ifdef EDGE_DET_DEBOUNCE_EN
  localparam int DB_LAT = DB;
`else
  localparam int DB_LAT = 0;
`endif
  // Edges from first sampling edge until level shows the new value.
  localparam int LAT = SS + DB_LAT;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   sig;
  logic [2*W-1:0] mode;
  logic [W-1:0]   clr;
  logic [W-1:0]   irq_en;
  logic [W-1:0]   level;
  logic [W-1:0]   pulse;
  logic [W-1:0]   sticky;
  logic [W-1:0]   ovf;
  logic           irq;

  int n_tests = 0;
  int n_fail  = 0;

  edge_det_bank #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .DB_CYCLES   (DB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sig    (sig),
    .mode   (mode),
    .clr    (clr),
    .irq_en (irq_en),
    .level  (level),
    .pulse  (pulse),
    .sticky (sticky),
    .ovf    (ovf),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  int          first_c;
  int          second_c;
  int          npulse;
  logic [W-1:0] acc_pulse;
  logic [W-1:0] acc_level;

  initial begin
    rst    = 1'b1;
    sig    = 4'h0;
    mode   = 8'h00;
    clr    = 4'h0;
    irq_en = 4'h0;
    #3;
    check("reset_level",  32'(level),  32'h0);
    check("reset_pulse",  32'(pulse),  32'h0);
    check("reset_sticky", 32'(sticky), 32'h0);
    check("reset_ovf",    32'(ovf),    32'h0);
    check("reset_irq",    32'(irq),    32'h0);
    ticks(2);
    rst = 1'b0;
    tick();

    // Channel 0 rise, mode 01, irq enabled.
    mode[1:0] = 2'b01;
    irq_en[0] = 1'b1;
    sig[0]    = 1'b1;
    ticks(LAT);
    check("s1_level_up",     32'(level[0]), 32'h1);
    check("s1_no_pulse_yet", 32'(pulse),    32'h0);
    check("s1_irq_low_yet",  32'(irq),      32'h0);
    tick();
    check("s1_pulse",  32'(pulse),  32'h1);
    check("s1_sticky", 32'(sticky), 32'h1);
    check("s1_irq",    32'(irq),    32'h1);
    tick();
    check("s1_pulse_gone", 32'(pulse),  32'h0);
    check("s1_sticky_hold", 32'(sticky), 32'h1);

    // Mode change on a steady high channel makes no pulse.
    mode[1:0] = 2'b11;
    tick();
    check("mode_change_no_pulse", 32'(pulse), 32'h0);
    clr = 4'hF;
    tick();
    clr = 4'h0;
    check("clr_sticky", 32'(sticky), 32'h0);
    check("clr_irq",    32'(irq),    32'h0);

    // Channel 1 both edges, 10-cycle high.
    mode[3:2] = 2'b11;
    npulse = 0; first_c = -1; second_c = -1;
    sig[1] = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (pulse[1]) begin
        npulse++;
        if (first_c < 0) first_c = c;
        else second_c = c;
      end
      if (c == 10) sig[1] = 1'b0;
    end
    check("s2_pulse_count", 32'(npulse),   32'd2);
    check("s2_rise_cycle",  32'(first_c),  32'(LAT + 1));
    check("s2_fall_cycle",  32'(second_c), 32'(LAT + 11));

    // Same with mode 00: level follows, no pulses.
    mode[3:2] = 2'b00;
    clr = 4'hF;
    tick();
    clr = 4'h0;
    acc_pulse = 4'h0;
    sig[1] = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      acc_pulse = acc_pulse | pulse;
      if (c == 9) check("s2_off_level_high", 32'(level[1]), 32'h1);
      if (c == 10) sig[1] = 1'b0;
    end
    check("s2_off_no_pulse", 32'(acc_pulse[1]), 32'h0);
    check("s2_off_level_low", 32'(level[1]), 32'h0);
    check("s2_off_no_sticky", 32'(sticky[1]), 32'h0);

    // Channel 2 overflow and clr vs set.
    mode[5:4] = 2'b01;
    sig[2] = 1'b1;
    ticks(LAT + 1);
    check("s3_rise1_pulse", 32'(pulse[2]), 32'h1);
    check("s3_rise1_ovf",   32'(ovf[2]),   32'h0);
    sig[2] = 1'b0;
    ticks(LAT + 3);
    sig[2] = 1'b1;
    ticks(LAT + 1);
    check("s3_rise2_pulse", 32'(pulse[2]), 32'h1);
    check("s3_rise2_ovf",   32'(ovf[2]),   32'h1);
    sig[2] = 1'b0;
    ticks(LAT + 3);
    check("s3_ovf_hold", 32'(ovf[2]), 32'h1);
    sig[2] = 1'b1;
    ticks(LAT);
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    check("s3_rise3_pulse",  32'(pulse[2]),  32'h1);
    check("s3_set_wins",     32'(sticky[2]), 32'h1);
    check("s3_ovf_cleared",  32'(ovf[2]),    32'h0);

    // All channels rise together.
    sig = 4'h0;
    ticks(LAT + 3);
    clr = 4'hF;
    tick();
    clr = 4'h0;
    check("s4_pre_sticky", 32'(sticky), 32'h0);
    check("s4_pre_ovf",    32'(ovf),    32'h0);
    mode   = 8'h55;
    irq_en = 4'h0;
    sig    = 4'hF;
    ticks(LAT + 1);
    check("s4_pulse_all",  32'(pulse),  32'hF);
    check("s4_sticky_all", 32'(sticky), 32'hF);
    check("s4_irq_masked", 32'(irq),    32'h0);
    irq_en = 4'b0100;
    #1;
    check("s4_irq_ch2", 32'(irq), 32'h1);
    tick();
    check("s4_pulse_once", 32'(pulse), 32'h0);

    // Reset mid-pulse abandons everything.
    irq_en = 4'hF;
    sig = 4'h0;
    ticks(LAT + 3);
    sig = 4'hF;
    ticks(LAT + 1);
    check("s5_pulse_before_rst", 32'(pulse), 32'hF);
    rst = 1'b1;
    #2;
    check("s5_rst_pulse",  32'(pulse),  32'h0);
    check("s5_rst_sticky", 32'(sticky), 32'h0);
    check("s5_rst_ovf",    32'(ovf),    32'h0);
    check("s5_rst_level",  32'(level),  32'h0);
    check("s5_rst_irq",    32'(irq),    32'h0);
    sig = 4'h0;
    ticks(2);
    rst = 1'b0;
    acc_pulse = 4'h0;
    acc_level = 4'h0;
    for (int c = 0; c < LAT + 4; c++) begin
      tick();
      acc_pulse = acc_pulse | pulse;
      acc_level = acc_level | level;
    end
    check("s5_no_residual_pulse", 32'(acc_pulse), 32'h0);
    check("s5_level_low",         32'(acc_level), 32'h0);

    // Releasing reset with input high reports a rise.
    rst = 1'b1;
    sig = 4'b1000;
    tick();
    rst = 1'b0;
    ticks(LAT + 1);
    check("s6_rise_after_rst", 32'(pulse), 32'h8);

`ifdef EDGE_DET_DEBOUNCE_EN
    // Short glitch must be filtered out.
    sig[0] = 1'b1;
    ticks(3);
    sig[0] = 1'b0;
    acc_pulse = 4'h0;
    acc_level = 4'h0;
    for (int c = 0; c < 20; c++) begin
      tick();
      acc_pulse = acc_pulse | pulse;
      acc_level = acc_level | level;
    end
    check("db_glitch_no_pulse", 32'(acc_pulse[0]), 32'h0);
    check("db_glitch_no_level", 32'(acc_level[0]), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
